// File: rtl/tsf_sync_loader_if.sv
// tsf_sync_loader_if: load-request sources, loader and TSF timer load-port bundle
interface tsf_sync_loader_if #(parameter int W = 64);
  logic [W-1:0] tsf_runtime_val;
  logic         sw_load_req;
  logic [W-1:0] sw_load_val;
  logic         bcn_valid;
  logic         bcn_ready;
  logic [W-1:0] bcn_ts;
  logic [W-1:0] bcn_rx_tsf;
  logic [15:0]  bcn_comp_us;
  logic         tsf_load_control;
  logic [W-1:0] tsf_load_val;
  logic         busy;
  logic         sync_done;
  logic         sync_skipped;
  logic [W-1:0] last_offset;
  modport master (
    output tsf_runtime_val, sw_load_req, sw_load_val, bcn_valid, bcn_ts, bcn_rx_tsf, bcn_comp_us,
    input  bcn_ready, tsf_load_control, tsf_load_val, busy, sync_done, sync_skipped, last_offset
  );
  modport slave (
    input  tsf_runtime_val, sw_load_req, sw_load_val, bcn_valid, bcn_ts, bcn_rx_tsf, bcn_comp_us,
    output bcn_ready, tsf_load_control, tsf_load_val, busy, sync_done, sync_skipped, last_offset
  );
endinterface

// File: rtl/tsf_sync_loader.sv
// tsf_sync_loader: drives the TSF timer load pulse from beacon or software values; TSF_SYNC_ADOPT_LATER_ONLY_EN skips beacons that would not move the timer forward
module tsf_sync_loader #(
  parameter int TIMER_WIDTH   = 64,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rstn,
  tsf_sync_loader_if.slave bus
);
  localparam int W = TIMER_WIDTH;
  typedef enum logic [2:0] {IDLE, CALC, ASSERT, RELEASE, GUARD} state_t;
  state_t       state_q;
  logic         pend_q, src_bcn_q, ctrl_q, done_q;
  logic [W-1:0] pend_val_q, ts_q, rx_q, val_q, off_q;
  logic [15:0]  comp_q, cnt_q;
  logic [W-1:0] new_d, diff_d;
  logic         ready_d;
  // new timer value, its offset from the running timer, and beacon acceptance
  always_comb begin
    new_d   = src_bcn_q ? ts_q + (bus.tsf_runtime_val - rx_q) + {{(W-16){1'b0}}, comp_q} : ts_q;
    diff_d  = new_d - bus.tsf_runtime_val;
    ready_d = (state_q == IDLE) && !pend_q && !bus.sw_load_req;
  end
`ifdef TSF_SYNC_ADOPT_LATER_ONLY_EN
  logic skip_q;
  assign bus.sync_skipped = skip_q;
`else
  assign bus.sync_skipped = 1'b0;
`endif
  assign bus.bcn_ready        = ready_d;
  assign bus.tsf_load_control = ctrl_q;
  assign bus.tsf_load_val     = val_q;
  assign bus.busy             = state_q != IDLE;
  assign bus.sync_done        = done_q;
  assign bus.last_offset      = off_q;
  // load sequencer: select source, compute, pulse the control line, then settle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      src_bcn_q  <= 1'b0;
      ts_q       <= '0;
      rx_q       <= '0;
      comp_q     <= '0;
      cnt_q      <= '0;
      ctrl_q     <= 1'b0;
      val_q      <= '0;
      done_q     <= 1'b0;
      off_q      <= '0;
`ifdef TSF_SYNC_ADOPT_LATER_ONLY_EN
      skip_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef TSF_SYNC_ADOPT_LATER_ONLY_EN
      skip_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q   <= CALC;
            src_bcn_q <= 1'b0;
            ts_q      <= pend_val_q;
            pend_q    <= 1'b0;
          end else if (bus.bcn_valid && ready_d) begin
            state_q   <= CALC;
            src_bcn_q <= 1'b1;
            ts_q      <= bus.bcn_ts;
            rx_q      <= bus.bcn_rx_tsf;
            comp_q    <= bus.bcn_comp_us;
          end
        end
        CALC: begin
`ifdef TSF_SYNC_ADOPT_LATER_ONLY_EN
          if (src_bcn_q && (diff_d[W-1] || diff_d == '0)) begin
            state_q <= IDLE;
            skip_q  <= 1'b1;
          end else
`endif
          begin
            state_q <= ASSERT;
            ctrl_q  <= 1'b1;
            val_q   <= new_d;
            off_q   <= diff_d;
            cnt_q   <= '0;
          end
        end
        ASSERT: begin
          if (src_bcn_q) val_q <= bus.tsf_runtime_val + off_q;
          if (cnt_q == 16'(PULSE_CYCLES - 1)) begin
            state_q <= RELEASE;
            ctrl_q  <= 1'b0;
          end else cnt_q <= cnt_q + 16'd1;
        end
        RELEASE: begin
          state_q <= GUARD;
          cnt_q   <= '0;
        end
        default: begin
          if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else cnt_q <= cnt_q + 16'd1;
        end
      endcase
      if (bus.sw_load_req) begin
        pend_q     <= 1'b1;
        pend_val_q <= bus.sw_load_val;
      end
    end
  end
endmodule
